vector_seq: RTL and testbench
=============================

VECTOR_SEQ -- requirements
Module: vector_seq

Interface
REQ-001 Parameter CHANNELS, default 8: number of data channels per vector, one per downstream force-format register.
REQ-002 Parameter ADDR_W, default 6: vector memory address width; depth = 2^ADDR_W words.
REQ-003 CLK  in  1  sole clock; every register updates on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 WR_EN  in  1  vector memory write strobe.
REQ-006 WR_ADDR  in  ADDR_W  write address.
REQ-007 WR_DATA  in  CHANNELS+2  write word, packed as {FF[1:0], DATA[CHANNELS-1:0]}.
REQ-008 LENGTH  in  ADDR_W+1  number of vectors per pass; valid range 1..2^ADDR_W.
REQ-009 REPEAT  in  8  extra passes; total passes = REPEAT+1.
REQ-010 START  in  1  single-cycle run request.
REQ-011 STOP  in  1  single-cycle abort request.
REQ-012 DATA_OUT  out  CHANNELS  per-channel data, one bit to each force-format register DATA input.
REQ-013 FF_OUT  out  2  format code, shared by all channels.
REQ-014 CLK_ENABLE  out  1  output-stage clock enable; high only when a vector is present.
REQ-015 BUSY  out  1  run in progress.
REQ-016 DONE  out  1  one-cycle pulse on normal completion.
REQ-017 WR_ERR  out  1  sticky flag: a write was attempted while BUSY.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, FINISH.
REQ-019 The vector memory SHALL be synchronous read, 1-cycle latency; writes SHALL take effect only when WR_EN=1 and BUSY=0.
REQ-020 In IDLE, START=1, STOP=0 and 1<=LENGTH<=2^ADDR_W SHALL capture LENGTH and REPEAT and enter RUN; any other START SHALL be ignored.
REQ-021 With START sampled at edge T, BUSY SHALL be high from cycle T+1; the word at address 0 SHALL appear on DATA_OUT/FF_OUT with CLK_ENABLE=1 in cycle T+2.
REQ-022 The FSM SHALL present one vector per cycle at addresses 0..LENGTH-1 in order; after address LENGTH-1 with passes remaining, it SHALL wrap to address 0 with no idle cycle.
REQ-023 CLK_ENABLE SHALL be high for exactly LENGTH*(REPEAT+1) consecutive cycles per run.
REQ-024 The cycle after the last vector SHALL be FINISH: DONE=1, BUSY=0, outputs at idle values. The next cycle SHALL be IDLE.
REQ-025 Idle output values: DATA_OUT=0, FF_OUT=2'b00 (force low), CLK_ENABLE=0.
REQ-026 STOP=1 in RUN SHALL abort; the next cycle SHALL be IDLE with idle output values, BUSY=0 and no DONE pulse.
REQ-027 STOP and START asserted together in IDLE: STOP SHALL win and the FSM SHALL stay in IDLE.
REQ-028 START during RUN or FINISH SHALL be ignored.
REQ-029 The pass counter SHALL be 8 bits; REPEAT=255 SHALL yield 256 passes without overflow.
REQ-030 A WR_EN while BUSY=1 SHALL set WR_ERR and SHALL leave memory unchanged; an accepted START SHALL clear WR_ERR.

Reset
REQ-031 RST=1 SHALL force IDLE, DATA_OUT=0, FF_OUT=2'b00, CLK_ENABLE=0, BUSY=0, DONE=0, WR_ERR=0 at the next edge, overriding all other inputs, including mid-run.
REQ-032 Reset SHALL NOT clear vector memory contents.

Verification
REQ-033 Write addr0..3 = 0x2A5, 0x35A, 0x0FF, 0x100 (CHANNELS=8); LENGTH=4, REPEAT=0; START -> DATA_OUT/FF_OUT = A5/10, 5A/11, FF/00, 00/01 in cycles T+2..T+5, DONE at T+6.
REQ-034 LENGTH=3, REPEAT=2 -> CLK_ENABLE high for exactly 9 cycles, address sequence 0,1,2,0,1,2,0,1,2, no gap, single DONE pulse.
REQ-035 STOP in the 3rd vector cycle of LENGTH=10 -> next cycle CLK_ENABLE=0, FF_OUT=00, BUSY=0, no DONE; a subsequent START runs normally.
REQ-036 WR_EN during RUN -> WR_ERR=1 and memory unchanged on readback run; next accepted START clears WR_ERR.
REQ-037 RST mid-run, then LENGTH=0 with START -> IDLE values at the next edge; START ignored, BUSY stays 0; START+STOP together -> stays IDLE.
REQ-038 LENGTH=2^ADDR_W, REPEAT=255 -> CLK_ENABLE high for 64*256=16384 cycles, then DONE.

Source files
------------

// File: rtl/vector_seq.sv
// Vector sequencer: plays LENGTH words from a local vector memory REPEAT+1 times,
// presenting one {FF, DATA} word per cycle to a bank of force-format registers.
module vector_seq #(
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [ADDR_W-1:0]     WR_ADDR,
    input  logic [CHANNELS+1:0]   WR_DATA,
    input  logic [ADDR_W:0]       LENGTH,
    input  logic [7:0]            REPEAT,
    input  logic                  START,
    input  logic                  STOP,
    output logic [CHANNELS-1:0]   DATA_OUT,
    output logic [1:0]            FF_OUT,
    output logic                  CLK_ENABLE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  WR_ERR
);

    localparam int WORD_W = CHANNELS + 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    logic [WORD_W-1:0]   mem [DEPTH];
    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   last_addr;
    logic [7:0]          pass;
    logic [7:0]          passes_m1;
    logic                issuing;
    logic [CHANNELS-1:0] data_p0;
    logic [1:0]          ff_p0;
    logic                vld_p0;
    logic                busy_r;
    logic                done_r;
    logic                wr_err_r;
    logic                start_ok;

    assign start_ok = START && !STOP && (LENGTH != '0) && (LENGTH <= MAX_LEN);

    // Memory contents survive reset; writes are locked out for the whole run.
    always_ff @(posedge CLK) begin
        if (WR_EN && !busy_r)
            mem[WR_ADDR] <= WR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            pass      <= '0;
            passes_m1 <= '0;
            issuing   <= 1'b0;
            data_p0   <= '0;
            ff_p0     <= 2'b00;
            vld_p0    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ff_p0   <= 2'b00;
            if (WR_EN && busy_r)
                wr_err_r <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= RUN;
                        busy_r    <= 1'b1;
                        wr_err_r  <= 1'b0;
                        last_addr <= LENGTH[ADDR_W-1:0] - ADDR_W'(1);
                        passes_m1 <= REPEAT;
                        addr      <= '0;
                        pass      <= '0;
                        issuing   <= 1'b1;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        issuing <= 1'b0;
                    end else if (issuing) begin
                        // Stage p0: synchronous memory read lands directly in the output register
                        vld_p0           <= 1'b1;
                        {ff_p0, data_p0} <= mem[addr];
                        if (addr == last_addr) begin
                            addr <= '0;
                            if (pass == passes_m1)
                                issuing <= 1'b0;
                            else
                                pass <= pass + 8'd1;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end else begin
                        // Last vector is on the outputs this cycle; next cycle reports completion
                        state  <= FINISH;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign DATA_OUT   = data_p0;
    assign FF_OUT     = ff_p0;
    assign CLK_ENABLE = vld_p0;
    assign BUSY       = busy_r;
    assign DONE       = done_r;
    assign WR_ERR     = wr_err_r;

endmodule

// File: tb/tb_vector_seq.sv
// Bench for vector_seq: table of known words plus randomized runs checked
// against a memory-image model of the expected vector stream.
module tb_vector_seq;

    localparam int CH    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          WR_EN = 1'b0;
    logic [AW-1:0] WR_ADDR = '0;
    logic [CH+1:0] WR_DATA = '0;
    logic [AW:0]   LENGTH = '0;
    logic [7:0]    REPEAT = '0;
    logic          START = 1'b0;
    logic          STOP = 1'b0;
    logic [CH-1:0] DATA_OUT;
    logic [1:0]    FF_OUT;
    logic          CLK_ENABLE;
    logic          BUSY;
    logic          DONE;
    logic          WR_ERR;

    vector_seq #(.CHANNELS(CH), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .LENGTH(LENGTH), .REPEAT(REPEAT), .START(START), .STOP(STOP),
        .DATA_OUT(DATA_OUT), .FF_OUT(FF_OUT), .CLK_ENABLE(CLK_ENABLE),
        .BUSY(BUSY), .DONE(DONE), .WR_ERR(WR_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CH+1:0] word;
        logic [CH-1:0] exp_data;
        logic [1:0]    exp_ff;
    } vec_t;

    vec_t          tbl [4];
    logic [CH+1:0] model_mem [DEPTH];
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    task automatic write_word(input int a, input logic [CH+1:0] d);
        WR_EN = 1'b1; WR_ADDR = AW'(a); WR_DATA = d;
        tick();
        WR_EN = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_ce"}, 32'(CLK_ENABLE), 0);
        chk({tag, "_data"}, 32'(DATA_OUT), 0);
        chk({tag, "_ff"}, 32'(FF_OUT), 0);
    endtask

    // Full run: expected stream is the model memory image replayed rep+1 times.
    task automatic run_check(input int len, input int rep);
        LENGTH = 7'(len); REPEAT = 8'(rep); START = 1'b1;
        tick();
        START = 1'b0;
        samp();
        chk("busy_t1", 32'(BUSY), 1);
        chk("ce_t1", 32'(CLK_ENABLE), 0);
        chk("wrerr_clr", 32'(WR_ERR), 0);
        for (int p = 0; p <= rep; p++) begin
            for (int a = 0; a < len; a++) begin
                tick(); samp();
                chk("run_ce", 32'(CLK_ENABLE), 1);
                chk("run_data", 32'(DATA_OUT), 32'(model_mem[a][CH-1:0]));
                chk("run_ff", 32'(FF_OUT), 32'(model_mem[a][CH+1:CH]));
                chk("run_busy", 32'(BUSY), 1);
            end
        end
        tick(); samp();
        chk("fin_done", 32'(DONE), 1);
        check_idle("fin");
        tick(); samp();
        chk("post_done", 32'(DONE), 0);
        chk("post_busy", 32'(BUSY), 0);
    endtask

    initial begin
        tbl[0] = '{addr: 6'd0, word: 10'h2A5, exp_data: 8'hA5, exp_ff: 2'b10};
        tbl[1] = '{addr: 6'd1, word: 10'h35A, exp_data: 8'h5A, exp_ff: 2'b11};
        tbl[2] = '{addr: 6'd2, word: 10'h0FF, exp_data: 8'hFF, exp_ff: 2'b00};
        tbl[3] = '{addr: 6'd3, word: 10'h100, exp_data: 8'h00, exp_ff: 2'b01};

        tick(); tick();
        RST = 1'b0;
        samp();
        check_idle("reset");
        chk("reset_done", 32'(DONE), 0);
        chk("reset_wrerr", 32'(WR_ERR), 0);

        // Known-word table, LENGTH=4 single pass
        for (int i = 0; i < 4; i++) write_word(int'(tbl[i].addr), tbl[i].word);
        LENGTH = 7'd4; REPEAT = 8'd0; START = 1'b1;
        tick();
        START = 1'b0;
        samp();
        chk("tbl_busy_t1", 32'(BUSY), 1);
        for (int i = 0; i < 4; i++) begin
            tick(); samp();
            chk("tbl_ce", 32'(CLK_ENABLE), 1);
            chk("tbl_data", 32'(DATA_OUT), 32'(tbl[i].exp_data));
            chk("tbl_ff", 32'(FF_OUT), 32'(tbl[i].exp_ff));
        end
        tick(); samp();
        chk("tbl_done", 32'(DONE), 1);
        check_idle("tbl_fin");
        tick();

        for (int a = 4; a < DEPTH; a++) write_word(a, 10'($urandom));
        run_check(3, 2);

        // STOP in the third vector cycle of a LENGTH=10 run
        LENGTH = 7'd10; REPEAT = 8'd0; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        samp();
        chk("abort_v3", 32'(DATA_OUT), 32'(model_mem[2][CH-1:0]));
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        samp();
        check_idle("abort");
        chk("abort_done", 32'(DONE), 0);
        tick(); samp();
        chk("abort_done2", 32'(DONE), 0);
        run_check(10, 0);

        // Write attempted while busy: flagged, memory untouched, START during RUN ignored
        LENGTH = 7'd10; REPEAT = 8'd0; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        WR_EN = 1'b1; WR_ADDR = '0; WR_DATA = ~model_mem[0]; START = 1'b1;
        tick();
        WR_EN = 1'b0; START = 1'b0;
        samp();
        chk("wrerr_set", 32'(WR_ERR), 1);
        for (int i = 0; i < 50 && BUSY; i++) tick();
        samp();
        chk("wrerr_drain", 32'(BUSY), 0);
        chk("wrerr_sticky", 32'(WR_ERR), 1);
        tick(); tick();
        run_check(4, 1);

        // Reset mid-run, then rejected STARTs
        LENGTH = 7'd20; REPEAT = 8'd0; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        WR_EN = 1'b1; WR_ADDR = 6'd5; WR_DATA = ~model_mem[5];
        tick();
        WR_EN = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        samp();
        check_idle("rst_mid");
        chk("rst_mid_wrerr", 32'(WR_ERR), 0);
        chk("rst_mid_done", 32'(DONE), 0);
        LENGTH = 7'd0; START = 1'b1;
        tick();
        START = 1'b0;
        samp(); chk("len0_busy", 32'(BUSY), 0);
        tick(); samp(); check_idle("len0");
        LENGTH = 7'd65; START = 1'b1;
        tick();
        START = 1'b0;
        samp(); chk("len65_busy", 32'(BUSY), 0);
        LENGTH = 7'd5; START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        samp(); chk("startstop_busy", 32'(BUSY), 0);
        tick(); samp(); check_idle("startstop");
        run_check(8, 0);

        // Randomized memory image and run shapes
        for (int a = 0; a < DEPTH; a++) write_word(a, 10'($urandom));
        for (int r = 0; r < 6; r++)
            run_check(int'($urandom_range(1, 64)), int'($urandom_range(0, 3)));

        run_check(64, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
